// File: rtl/oup_ulpi_link.sv
`default_nettype none
// ============================================================================
//  Module   : oup_ulpi_link
//  Purpose  : ULPI link-side register access engine. Executes NOP, REG_WRITE
//             and REG_READ instructions on the ULPI bus. Optionally decodes
//             RX CMD bytes sent by the PHY while the link is idle.
//  Build    : define OUP_ULPI_RXCMD_EN to enable RX CMD decoding; when it is
//             undefined rx_cmd_byte_o / rx_cmd_valid_o are tied to 0.
//  Ports    : ulpi_clk_i, rst_i          - clock, sync active-high reset
//             ins_instruction_i[7:0]     - 00 NOP, 01 REG_WRITE, 02 REG_READ
//             ins_exec_i / ins_reset_i   - start / abort an instruction
//             ins_exec_done_o / ins_exec_aborted_o - one-cycle result pulses
//             ins_busy_o                 - instruction pending or running
//             phyreg_addr_i / phyreg_data_i - register address / write data
//             phyreg_data_o / phyreg_data_valid_o - read result and strobe
//             rx_cmd_byte_o / rx_cmd_valid_o - last RX CMD byte and strobe
//             ulpi_data_i/o, ulpi_data_oe_o, ulpi_dir_i, ulpi_nxt_i,
//             ulpi_stp_o                 - ULPI bus (tristate resolved above)
//  Revision : 1.0 - initial release
// ============================================================================
module oup_ulpi_link #(
    parameter int NXT_TIMEOUT = 255
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_i,
    input  logic [7:0] ins_instruction_i,
    input  logic       ins_exec_i,
    input  logic       ins_reset_i,
    output logic       ins_exec_done_o,
    output logic       ins_exec_aborted_o,
    output logic       ins_busy_o,
    input  logic [7:0] phyreg_addr_i,
    input  logic [7:0] phyreg_data_i,
    output logic [7:0] phyreg_data_o,
    output logic       phyreg_data_valid_o,
    output logic [7:0] rx_cmd_byte_o,
    output logic       rx_cmd_valid_o,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o
);

    localparam logic [7:0] INS_NOP   = 8'h00;
    localparam logic [7:0] INS_WRITE = 8'h01;
    localparam logic [7:0] INS_READ  = 8'h02;
    // Counter value on the last cycle a command may wait for nxt.
    localparam logic [7:0] TO_LAST   = 8'(NXT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_CMD   = 3'd1,
        W_DATA  = 3'd2,
        W_STP   = 3'd3,
        R_CMD   = 3'd4,
        R_TURN  = 3'd5,
        R_DATA  = 3'd6,
        R_TBACK = 3'd7
    } state_t;

    state_t      state_q;
    logic [5:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        is_read_q;
    logic        pending_q;
    logic        dir_prev_q;
    logic [7:0]  cnt_q;
    // Set when the current transfer is being torn down rather than completed;
    // W_STP and R_TBACK consult it to choose between done and aborted.
    logic        abort_q;
    logic        done_q;
    logic        aborted_q;
    logic [7:0]  phyreg_data_q;
    logic        phyreg_valid_q;
`ifdef OUP_ULPI_RXCMD_EN
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q;
`endif

    logic        w_drive;
    logic        w_timeout;

    assign w_drive   = (state_q == W_CMD) || (state_q == W_DATA) ||
                       (state_q == W_STP) || (state_q == R_CMD);
    assign w_timeout = !ulpi_nxt_i && (cnt_q == TO_LAST);

    always_ff @(posedge ulpi_clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            addr_q         <= 6'd0;
            wdata_q        <= 8'd0;
            is_read_q      <= 1'b0;
            pending_q      <= 1'b0;
            dir_prev_q     <= 1'b0;
            cnt_q          <= 8'd0;
            abort_q        <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            phyreg_data_q  <= 8'd0;
            phyreg_valid_q <= 1'b0;
`ifdef OUP_ULPI_RXCMD_EN
            rx_byte_q      <= 8'd0;
            rx_valid_q     <= 1'b0;
`endif
        end else begin
            dir_prev_q     <= ulpi_dir_i;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            phyreg_valid_q <= 1'b0;
`ifdef OUP_ULPI_RXCMD_EN
            rx_valid_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q   <= 8'd0;
                    abort_q <= 1'b0;
`ifdef OUP_ULPI_RXCMD_EN
                    // PHY-owned bus, past its turnaround cycle, no nxt: RX CMD.
                    if (ulpi_dir_i && dir_prev_q && !ulpi_nxt_i) begin
                        rx_byte_q  <= ulpi_data_i;
                        rx_valid_q <= 1'b1;
                    end
`endif
                    if (ins_reset_i) begin
                        if (pending_q) begin
                            aborted_q <= 1'b1;
                        end
                        pending_q <= 1'b0;
                    end else if (pending_q) begin
                        // Only start once the bus has been ours for two cycles.
                        if (!ulpi_dir_i && !dir_prev_q) begin
                            pending_q <= 1'b0;
                            state_q   <= is_read_q ? R_CMD : W_CMD;
                        end
                    end else if (ins_exec_i) begin
                        addr_q    <= phyreg_addr_i[5:0];
                        wdata_q   <= phyreg_data_i;
                        is_read_q <= (ins_instruction_i == INS_READ);
                        if (ins_instruction_i == INS_NOP) begin
                            done_q <= 1'b1;
                        end else if (((ins_instruction_i == INS_WRITE) ||
                                      (ins_instruction_i == INS_READ)) &&
                                     (phyreg_addr_i <= 8'h3F)) begin
                            pending_q <= 1'b1;
                        end else begin
                            aborted_q <= 1'b1;
                        end
                    end
                end

                W_CMD, W_DATA, R_CMD: begin
                    if (ulpi_dir_i) begin
                        // PHY grabbed the bus: stp must not be driven.
                        aborted_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (ins_reset_i || w_timeout) begin
                        abort_q <= 1'b1;
                        state_q <= W_STP;
                    end else if (ulpi_nxt_i) begin
                        cnt_q <= 8'd0;
                        case (state_q)
                            W_CMD:   state_q <= W_DATA;
                            W_DATA:  state_q <= W_STP;
                            default: state_q <= R_TURN;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                W_STP: begin
                    if (ins_reset_i || abort_q) begin
                        aborted_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end

                R_TURN: begin
                    if (ins_reset_i || !ulpi_dir_i) begin
                        aborted_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        state_q <= R_DATA;
                    end
                end

                R_DATA: begin
                    if (ins_reset_i) begin
                        aborted_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        // nxt here means the PHY replaced the register data
                        // with a USB receive; drop the read but let the PHY
                        // finish before returning to idle.
                        if (ulpi_nxt_i) begin
                            abort_q <= 1'b1;
                        end else begin
                            phyreg_data_q  <= ulpi_data_i;
                            phyreg_valid_q <= 1'b1;
                        end
                        state_q <= R_TBACK;
                    end
                end

                R_TBACK: begin
                    if (ins_reset_i) begin
                        aborted_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (!ulpi_dir_i) begin
                        if (abort_q) begin
                            aborted_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ulpi_data_o = 8'h00;
        if (ulpi_data_oe_o) begin
            case (state_q)
                W_CMD:   ulpi_data_o = {2'b10, addr_q};
                W_DATA:  ulpi_data_o = wdata_q;
                R_CMD:   ulpi_data_o = {2'b11, addr_q};
                default: ulpi_data_o = 8'h00;
            endcase
        end
    end

    assign ulpi_data_oe_o      = w_drive && !ulpi_dir_i;
    assign ulpi_stp_o          = (state_q == W_STP);
    assign ins_busy_o          = pending_q || (state_q != IDLE);
    assign ins_exec_done_o     = done_q;
    assign ins_exec_aborted_o  = aborted_q;
    assign phyreg_data_o       = phyreg_data_q;
    assign phyreg_data_valid_o = phyreg_valid_q;
`ifdef OUP_ULPI_RXCMD_EN
    assign rx_cmd_byte_o       = rx_byte_q;
    assign rx_cmd_valid_o      = rx_valid_q;
`else
    assign rx_cmd_byte_o       = 8'h00;
    assign rx_cmd_valid_o      = 1'b0;
`endif

endmodule
`default_nettype wire
